onehot_mux_pipe: RTL and testbench

//  Parametrised N-way one-hot-select multiplexer with a registered, valid/ready-handshaked output.

---
 rtl/onehot_mux_pipe_if.sv | 28 ++
 rtl/onehot_mux_pipe.sv | 127 ++++++++++++
 tb/tb_onehot_mux_pipe.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/onehot_mux_pipe_if.sv
// Handshake bundle for onehot_mux_pipe: upstream select/data beat and downstream registered beat.
interface onehot_mux_pipe_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned IDX_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (drives inputs, sinks outputs).
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_err, out_valid
  );

  // Mux block side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_err, out_valid
  );
endinterface

// File: rtl/onehot_mux_pipe.sv
// N-way one-hot select mux with registered valid/ready output, 2-entry skid buffer,
// illegal-select fallback to DEFAULT_IDX and a saturating illegal-select counter.
module onehot_mux_pipe #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned DEFAULT_IDX = NUM_IN - 1,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_mux_pipe_if.slave     bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_t      state_q, state_nxt;
  beat_t       or_q, sk_q, in_beat;
  logic        out_valid_q, in_ready_q;
  logic        accept, emit;
  logic        ld_or_in, ld_or_sk, ld_sk;
  logic [NUM_IN-1:0] sel_g;
  logic        legal;

  // Select decode; select is masked by valid so an undriven select cannot propagate.
  always_comb begin
    sel_g        = bus.in_valid ? bus.in_sel : '0;
    legal        = (sel_g != '0) && ((sel_g & (sel_g - NUM_IN'(1))) == '0);
    in_beat.idx  = IDX_W'(DEFAULT_IDX);
    in_beat.err  = 1'b1;
    in_beat.data = '0;
    if (legal) begin
      in_beat.err = 1'b0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (sel_g[i]) in_beat.idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (in_beat.idx == IDX_W'(i)) in_beat.data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_nxt;
  end

  // Occupancy FSM: OR holds the head beat, SK catches one beat while OR is stalled.
  always_comb begin
    state_nxt = state_q;
    ld_or_in  = 1'b0;
    ld_or_sk  = 1'b0;
    ld_sk     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          ld_or_in  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && emit) begin
          ld_or_in = 1'b1;
        end else if (accept) begin
          ld_sk     = 1'b1;
          state_nxt = ST_FULL;
        end else if (emit) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          ld_or_sk  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Beat storage and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q        <= '0;
      sk_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (ld_or_in)      or_q <= in_beat;
      else if (ld_or_sk) or_q <= sk_q;
      if (ld_sk)         sk_q <= in_beat;
      out_valid_q <= (state_nxt != ST_EMPTY);
      in_ready_q  <= (state_nxt != ST_FULL);
    end
  end

  // Saturating illegal-select counter; clear wins over history but not over the current beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (accept && in_beat.err) ? ERR_CNT_W'(1) : '0;
    end else if (accept && in_beat.err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = or_q.data;
  assign bus.out_idx   = or_q.idx;
  assign bus.out_err   = or_q.err;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Bench for onehot_mux_pipe: directed cases on a 3x5-bit instance, random traffic on an 8x32-bit one.
module tb_onehot_mux_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_mux_pipe_if #(.WIDTH(5),  .NUM_IN(3)) s_if ();
  onehot_mux_pipe_if #(.WIDTH(32), .NUM_IN(8)) b_if ();

  logic       s_clr, b_clr;
  logic [1:0] s_cnt;
  logic [7:0] b_cnt;

  onehot_mux_pipe #(.WIDTH(5), .NUM_IN(3), .ERR_CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s_if), .err_clr(s_clr), .err_cnt(s_cnt)
  );

  onehot_mux_pipe #(.WIDTH(32), .NUM_IN(8)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .err_clr(b_clr), .err_cnt(b_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sq[$];
  logic [63:0] bq[$];
  int          s_cnt_m = 0;
  int          b_cnt_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: exactly one bit set selects it, anything else routes the last input with err.
  function automatic logic [63:0] model_beat(input logic [255:0] d, input logic [7:0] sel,
                                             input int n, input int w, input int iw);
    int          idx = n - 1;
    logic        err = 1'b1;
    logic [63:0] field;
    if ($countones(sel) == 1) begin
      for (int i = 0; i < n; i++) if (sel[i]) begin idx = i; err = 1'b0; end
    end
    field = 64'(d >> (idx * w)) & ((64'd1 << w) - 64'd1);
    return (64'(err) << (w + iw)) | (64'(idx) << w) | field;
  endfunction

  function automatic int next_cnt(input int cnt, input bit acc_err, input bit clr, input int maxv);
    if (clr) return acc_err ? 1 : 0;
    if (acc_err && cnt < maxv) return cnt + 1;
    return cnt;
  endfunction

  // One cycle on the small instance: check current outputs, drive, advance model, clock.
  task automatic step_s(input logic v, input logic [2:0] sel, input logic [14:0] d,
                        input logic rdy, input logic clr);
    logic [63:0] exp_beat;
    bit          acc, emt;
    check("s_in_ready", 64'(s_if.in_ready), 64'(sq.size() < 2));
    check("s_out_valid", 64'(s_if.out_valid), 64'(sq.size() > 0));
    if (sq.size() > 0)
      check("s_beat", 64'({s_if.out_err, s_if.out_idx, s_if.out_data}), sq[0]);
    check("s_err_cnt", 64'(s_cnt), 64'(s_cnt_m));
    s_if.in_valid  = v;
    s_if.in_sel    = sel;
    s_if.in_data   = d;
    s_if.out_ready = rdy;
    s_clr          = clr;
    exp_beat = model_beat(256'(d), 8'(sel), 3, 5, 2);
    acc = v && (sq.size() < 2);
    emt = rdy && (sq.size() > 0);
    s_cnt_m = next_cnt(s_cnt_m, acc && exp_beat[7], clr, 3);
    if (emt) void'(sq.pop_front());
    if (acc) sq.push_back(exp_beat);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of random traffic on the large instance.
  task automatic step_b();
    logic [63:0]  exp_beat;
    logic [255:0] d;
    logic [7:0]   sel;
    logic         v, rdy, clr;
    bit           acc, emt;
    check("b_in_ready", 64'(b_if.in_ready), 64'(bq.size() < 2));
    check("b_out_valid", 64'(b_if.out_valid), 64'(bq.size() > 0));
    if (bq.size() > 0)
      check("b_beat", 64'({b_if.out_err, b_if.out_idx, b_if.out_data}), bq[0]);
    check("b_err_cnt", 64'(b_cnt), 64'(b_cnt_m));
    v   = ($urandom_range(0, 9) < 7);
    rdy = ($urandom_range(0, 9) < 6);
    clr = ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 9) < 7) sel = 8'(1 << $urandom_range(0, 7));
    else                          sel = 8'($urandom);
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    b_if.in_valid  = v;
    b_if.in_sel    = sel;
    b_if.in_data   = d;
    b_if.out_ready = rdy;
    b_clr          = clr;
    exp_beat = model_beat(d, sel, 8, 32, 3);
    acc = v && (bq.size() < 2);
    emt = rdy && (bq.size() > 0);
    b_cnt_m = next_cnt(b_cnt_m, acc && exp_beat[35], clr, 255);
    if (emt) void'(bq.pop_front());
    if (acc) bq.push_back(exp_beat);
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [14:0] ABC = {5'h1F, 5'h0B, 5'h0A};

  initial begin
    s_if.in_valid = 1'b0; s_if.in_sel = '0; s_if.in_data = '0; s_if.out_ready = 1'b0; s_clr = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_sel = '0; b_if.in_data = '0; b_if.out_ready = 1'b0; b_clr = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_out_valid", 64'(s_if.out_valid), 64'(0));
    check("rst_out_data", 64'(s_if.out_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Legal decode, back to back
    step_s(1'b1, 3'b001, ABC, 1'b1, 1'b0);
    check("t2_a", 64'({s_if.out_valid, s_if.out_err, s_if.out_idx, s_if.out_data}), 64'({1'b1, 1'b0, 2'd0, 5'h0A}));
    step_s(1'b1, 3'b010, ABC, 1'b1, 1'b0);
    check("t2_b", 64'({s_if.out_valid, s_if.out_err, s_if.out_idx, s_if.out_data}), 64'({1'b1, 1'b0, 2'd1, 5'h0B}));
    step_s(1'b1, 3'b100, ABC, 1'b1, 1'b0);
    check("t2_c", 64'({s_if.out_valid, s_if.out_err, s_if.out_idx, s_if.out_data}), 64'({1'b1, 1'b0, 2'd2, 5'h1F}));

    // Illegal selects route to input 2 and count
    step_s(1'b1, 3'b000, ABC, 1'b1, 1'b0);
    check("t3_zero", 64'({s_if.out_err, s_if.out_idx, s_if.out_data}), 64'({1'b1, 2'd2, 5'h1F}));
    step_s(1'b1, 3'b011, ABC, 1'b1, 1'b0);
    check("t3_multi", 64'({s_if.out_err, s_if.out_idx, s_if.out_data}), 64'({1'b1, 2'd2, 5'h1F}));
    check("t3_cnt", 64'(s_cnt), 64'(2));
    step_s(1'b0, 3'b000, ABC, 1'b1, 1'b0);

    // Backpressure: OR and SK fill, third beat stalls, then everything drains in order
    step_s(1'b1, 3'b001, ABC, 1'b0, 1'b0);
    step_s(1'b1, 3'b010, ABC, 1'b0, 1'b0);
    check("t4_stall", 64'(s_if.in_ready), 64'(0));
    step_s(1'b1, 3'b100, ABC, 1'b0, 1'b0);
    check("t4_hold", 64'({s_if.out_idx, s_if.out_data}), 64'({2'd0, 5'h0A}));
    step_s(1'b1, 3'b100, ABC, 1'b1, 1'b0);
    step_s(1'b1, 3'b100, ABC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_s(1'b0, 3'b000, ABC, 1'b1, 1'b0);
    check("t4_drained", 64'(s_if.out_valid), 64'(0));

    // Counter clear and saturation
    step_s(1'b0, 3'b000, ABC, 1'b1, 1'b1);
    check("t5_clr", 64'(s_cnt), 64'(0));
    for (int i = 0; i < 5; i++) step_s(1'b1, 3'b000, ABC, 1'b1, 1'b0);
    check("t5_sat", 64'(s_cnt), 64'(3));
    step_s(1'b1, 3'b110, ABC, 1'b1, 1'b1);
    check("t5_clr_acc", 64'(s_cnt), 64'(1));
    step_s(1'b0, 3'b000, ABC, 1'b1, 1'b0);

    // Async reset with both registers full
    step_s(1'b1, 3'b101, ABC, 1'b0, 1'b0);
    step_s(1'b1, 3'b001, ABC, 1'b0, 1'b0);
    step_s(1'b0, 3'b000, ABC, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_out_valid", 64'(s_if.out_valid), 64'(0));
    check("t1_err_cnt", 64'(s_cnt), 64'(0));
    check("t1_out_data", 64'({s_if.out_err, s_if.out_idx, s_if.out_data}), 64'(0));
    sq.delete();
    s_cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t1_in_ready", 64'(s_if.in_ready), 64'(1));
    step_s(1'b1, 3'b010, ABC, 1'b1, 1'b0);
    step_s(1'b0, 3'b000, ABC, 1'b1, 1'b0);

    // Random traffic on the wide instance
    for (int c = 0; c < 10000; c++) step_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
